reg_write_arbiter: RTL and testbench

- Shares the register file's single write port between two sources:
  - pipeline writeback (WB): absolute priority, never back-pressured.
  - multi-cycle execution unit (AUX, e.g. mul/div): valid/ready handshake, buffered in a small FIFO.
- Drives the register file write port, exports a pending-destination mask to the hazard unit, and requests a pipeline stall when AUX results starve.

---
 rtl/reg_arb_pkg.sv | 25 ++
 rtl/reg_wr_fifo.sv | 112 +++++++++++
 rtl/reg_write_arbiter.sv | 141 ++++++++++++++
 tb/tb_reg_write_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_arb_pkg.sv
// -----------------------------------------------------------------------------
// reg_arb_pkg
//   Shared definitions for the register-file write arbiter:
//   - XLEN_DEFAULT : default data width of a write request
//   - REG_ADDR_W   : architectural register index width
//   - NUM_REGS     : number of architectural registers
//   - wr_req_t     : packed {rd, data} write request at the default width
//   - rd_onehot()  : one-hot decode of a register index
// -----------------------------------------------------------------------------
package reg_arb_pkg;

   localparam int XLEN_DEFAULT = 64;
   localparam int REG_ADDR_W   = 5;
   localparam int NUM_REGS     = 32;

   typedef struct packed {
      logic [REG_ADDR_W-1:0]   rd;
      logic [XLEN_DEFAULT-1:0] data;
   } wr_req_t;

   function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
      return NUM_REGS'(1) << rd;
   endfunction

endpackage : reg_arb_pkg

// File: rtl/reg_wr_fifo.sv
// -----------------------------------------------------------------------------
// reg_wr_fifo
//   Synchronous FIFO of pending register writes {rd, data}. Push is ignored
//   when full and pop is ignored when empty, so the caller may present either
//   unconditionally. Entry rd fields and per-entry valid bits are exported so
//   the parent can build a pending-destination mask.
//
// Ports:
//   clk, rstn            clock, synchronous active-low reset
//   push_i               write {push_rd_i, push_data_i} at the tail
//   pop_i                drop the head entry
//   head_rd_o/data_o     current head entry (meaningful when !empty_o)
//   full_o, empty_o      occupancy flags from the registered count
//   count_o              number of valid entries, 0..DEPTH
//   entry_rd_o           rd field of every storage slot
//   entry_valid_o        slot holds a live entry
// -----------------------------------------------------------------------------
module reg_wr_fifo
   import reg_arb_pkg::*;
#(
   parameter int XLEN  = XLEN_DEFAULT,
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic                                clk,
   input  logic                                rstn,
   input  logic                                push_i,
   input  logic [REG_ADDR_W-1:0]               push_rd_i,
   input  logic [XLEN-1:0]                     push_data_i,
   input  logic                                pop_i,
   output logic [REG_ADDR_W-1:0]               head_rd_o,
   output logic [XLEN-1:0]                     head_data_o,
   output logic                                full_o,
   output logic                                empty_o,
   output logic [CNT_W-1:0]                    count_o,
   output logic [DEPTH-1:0][REG_ADDR_W-1:0]    entry_rd_o,
   output logic [DEPTH-1:0]                    entry_valid_o
);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q,  count_d;

   logic [DEPTH-1:0][REG_ADDR_W-1:0] rd_mem_q;
   logic [DEPTH-1:0][XLEN-1:0]       data_mem_q;

   logic push_ok;
   logic pop_ok;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i  && !empty_o;

   // NOTE: every always_comb output gets a default first, so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      // DEPTH is a power of two, so pointers wrap by natural overflow.
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is deliberately not reset; liveness comes from the pointers
   // and count, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         rd_mem_q[wr_ptr_q]   <= push_rd_i;
         data_mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   assign head_rd_o   = rd_mem_q[rd_ptr_q];
   assign head_data_o = data_mem_q[rd_ptr_q];
   assign count_o     = count_q;
   assign entry_rd_o  = rd_mem_q;

   // A slot is live when its distance from the read pointer (mod DEPTH) is
   // below the occupancy count.
   always_comb begin
      logic [PTR_W-1:0] offset;
      offset        = '0;
      entry_valid_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offset           = PTR_W'(i) - rd_ptr_q;
         entry_valid_o[i] = ({1'b0, offset} < count_q);
      end
   end

endmodule : reg_wr_fifo

// File: rtl/reg_write_arbiter.sv
// -----------------------------------------------------------------------------
// reg_write_arbiter
//   Shares the register file's single write port between pipeline writeback
//   (absolute priority, never stalled) and a multi-cycle AUX unit whose
//   results are buffered in a small FIFO and drained in WB bubbles. Exports a
//   pending-destination mask and requests a pipeline stall when the FIFO head
//   has waited STARVE_LIMIT cycles.
//
// Ports:
//   clk, rstn                      clock, synchronous active-low reset
//   wb_write, wb_rd, wb_data       writeback request (rd 0 is a no-op)
//   aux_valid, aux_ready           AUX handshake; ready = FIFO not full
//   aux_rd, aux_data               AUX result (rd 0 acknowledged, dropped)
//   rf_write, rf_rd, rf_wdata      register file write port (combinational)
//   pending_mask                   bit r set iff a buffered entry targets r
//   pipe_stall                     registered stall request on starvation
// -----------------------------------------------------------------------------
module reg_write_arbiter
   import reg_arb_pkg::*;
#(
   parameter int XLEN         = XLEN_DEFAULT,
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  wb_write,
   input  logic [REG_ADDR_W-1:0] wb_rd,
   input  logic [XLEN-1:0]       wb_data,
   input  logic                  aux_valid,
   output logic                  aux_ready,
   input  logic [REG_ADDR_W-1:0] aux_rd,
   input  logic [XLEN-1:0]       aux_data,
   output logic                  rf_write,
   output logic [REG_ADDR_W-1:0] rf_rd,
   output logic [XLEN-1:0]       rf_wdata,
   output logic [NUM_REGS-1:0]   pending_mask,
   output logic                  pipe_stall
);

   localparam int CNT_W    = $clog2(DEPTH) + 1;
   localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

   logic                             wb_active;
   logic                             fifo_push;
   logic                             fifo_pop;
   logic                             fifo_full;
   logic                             fifo_empty;
   logic [CNT_W-1:0]                 fifo_count;
   logic [REG_ADDR_W-1:0]            head_rd;
   logic [XLEN-1:0]                  head_data;
   logic [DEPTH-1:0][REG_ADDR_W-1:0] entry_rd;
   logic [DEPTH-1:0]                 entry_valid;

   logic [STARVE_W-1:0] starve_q, starve_d;
   logic                pipe_stall_q, pipe_stall_d;

   assign wb_active = wb_write && (wb_rd != '0);

   // Ready depends only on registered occupancy: a pop in the same cycle does
   // not open a slot while full.
   assign aux_ready = !fifo_full;
   assign fifo_push = aux_valid && aux_ready && (aux_rd != '0);
   assign fifo_pop  = !wb_active && !fifo_empty;

   reg_wr_fifo #(
      .XLEN  (XLEN),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk           (clk),
      .rstn          (rstn),
      .push_i        (fifo_push),
      .push_rd_i     (aux_rd),
      .push_data_i   (aux_data),
      .pop_i         (fifo_pop),
      .head_rd_o     (head_rd),
      .head_data_o   (head_data),
      .full_o        (fifo_full),
      .empty_o       (fifo_empty),
      .count_o       (fifo_count),
      .entry_rd_o    (entry_rd),
      .entry_valid_o (entry_valid)
   );

   // Write-port mux: WB wins outright, the FIFO head fills bubbles.
   always_comb begin
      rf_write = 1'b0;
      rf_rd    = '0;
      rf_wdata = '0;
      if (wb_active) begin
         rf_write = 1'b1;
         rf_rd    = wb_rd;
         rf_wdata = wb_data;
      end else if (!fifo_empty) begin
         rf_write = 1'b1;
         rf_rd    = head_rd;
         rf_wdata = head_data;
      end
   end

   always_comb begin
      pending_mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (entry_valid[i]) pending_mask = pending_mask | rd_onehot(entry_rd[i]);
      end
      // r0 is never written, so it is never pending.
      pending_mask[0] = 1'b0;
   end

   // The starve counter measures how long the current head has been blocked.
   // The stall is raised on the edge where the count reaches the limit and is
   // held until the head finally drains.
   always_comb begin
      starve_d     = starve_q;
      pipe_stall_d = pipe_stall_q;
      if (fifo_pop || (fifo_count == '0)) begin
         starve_d = '0;
      end else if (starve_q != STARVE_MAX) begin
         starve_d = starve_q + STARVE_W'(1);
      end
      if (fifo_pop) begin
         pipe_stall_d = 1'b0;
      end else if (starve_d == STARVE_MAX) begin
         pipe_stall_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         starve_q     <= '0;
         pipe_stall_q <= 1'b0;
      end else begin
         starve_q     <= starve_d;
         pipe_stall_q <= pipe_stall_d;
      end
   end

   assign pipe_stall = pipe_stall_q;

endmodule : reg_write_arbiter

// File: tb/tb_reg_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_reg_write_arbiter
//   Directed bench for reg_write_arbiter at default parameters (XLEN=64,
//   DEPTH=4, STARVE_LIMIT=8). Inputs change 1 time unit after the rising edge;
//   outputs are sampled 3 time units after the rising edge.
// -----------------------------------------------------------------------------
module tb_reg_write_arbiter;
   import reg_arb_pkg::*;

   logic        clk;
   logic        rstn;
   logic        wb_write;
   logic [4:0]  wb_rd;
   logic [63:0] wb_data;
   logic        aux_valid;
   logic        aux_ready;
   logic [4:0]  aux_rd;
   logic [63:0] aux_data;
   logic        rf_write;
   logic [4:0]  rf_rd;
   logic [63:0] rf_wdata;
   logic [31:0] pending_mask;
   logic        pipe_stall;

   int n_checks = 0;
   int n_fail   = 0;

   reg_write_arbiter #(
      .XLEN         (64),
      .DEPTH        (4),
      .STARVE_LIMIT (8)
   ) dut (
      .clk          (clk),
      .rstn         (rstn),
      .wb_write     (wb_write),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data),
      .aux_valid    (aux_valid),
      .aux_ready    (aux_ready),
      .aux_rd       (aux_rd),
      .aux_data     (aux_data),
      .rf_write     (rf_write),
      .rf_rd        (rf_rd),
      .rf_wdata     (rf_wdata),
      .pending_mask (pending_mask),
      .pipe_stall   (pipe_stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      wb_write  = 1'b0;
      wb_rd     = '0;
      wb_data   = '0;
      aux_valid = 1'b0;
      aux_rd    = '0;
      aux_data  = '0;
   endtask

   task automatic set_wb(input logic [4:0] rd, input logic [63:0] d);
      wb_write = 1'b1;
      wb_rd    = rd;
      wb_data  = d;
   endtask

   task automatic set_aux(input wr_req_t req);
      aux_valid = 1'b1;
      aux_rd    = req.rd;
      aux_data  = req.data;
   endtask

   initial begin
      // Reset then idle.
      rstn = 1'b0;
      idle();
      tick();
      tick();
      rstn = 1'b1;
      settle();
      check("rst_rf_write",  64'(rf_write),     64'd0);
      check("rst_rf_rd",     64'(rf_rd),        64'd0);
      check("rst_rf_wdata",  rf_wdata,          64'd0);
      check("rst_aux_ready", 64'(aux_ready),    64'd1);
      check("rst_pending",   64'(pending_mask), 64'd0);
      check("rst_stall",     64'(pipe_stall),   64'd0);
      tick();

      // WB only, four back-to-back writes, zero latency.
      for (int c = 0; c < 4; c++) begin
         set_wb(5'd5, 64'h1234);
         settle();
         check("wb_rf_write",  64'(rf_write),     64'd1);
         check("wb_rf_rd",     64'(rf_rd),        64'd5);
         check("wb_rf_wdata",  rf_wdata,          64'h1234);
         check("wb_pending",   64'(pending_mask), 64'd0);
         tick();
      end
      idle();

      // Single AUX push while WB idle: one cycle latency.
      set_aux('{rd: 5'd7, data: 64'hDEAD});
      settle();
      check("aux0_ready",    64'(aux_ready),    64'd1);
      check("aux0_rf_write", 64'(rf_write),     64'd0);
      check("aux0_pending",  64'(pending_mask), 64'd0);
      tick();
      idle();
      settle();
      check("aux1_rf_write", 64'(rf_write),     64'd1);
      check("aux1_rf_rd",    64'(rf_rd),        64'd7);
      check("aux1_rf_wdata", rf_wdata,          64'hDEAD);
      check("aux1_pending",  64'(pending_mask), 64'h80);
      tick();
      settle();
      check("aux2_rf_write", 64'(rf_write),     64'd0);
      check("aux2_pending",  64'(pending_mask), 64'd0);
      tick();

      // WB busy every cycle, five AUX results rd 1..5.
      set_wb(5'd10, 64'hAAAA);
      for (int k = 1; k <= 4; k++) begin
         set_aux('{rd: 5'(k), data: 64'(256 + k)});
         settle();
         check("busy_ready",  64'(aux_ready), 64'd1);
         check("busy_rf_rd",  64'(rf_rd),     64'd10);
         check("busy_wdata",  rf_wdata,       64'hAAAA);
         tick();
      end
      set_aux('{rd: 5'd5, data: 64'h105});
      settle();
      check("full_ready",   64'(aux_ready),    64'd0);
      check("full_pending", 64'(pending_mask), 64'h1E);
      check("full_stall",   64'(pipe_stall),   64'd0);
      tick();
      for (int c = 5; c <= 8; c++) begin
         settle();
         check("prelimit_stall", 64'(pipe_stall), 64'd0);
         tick();
      end
      settle();
      check("starve_stall",   64'(pipe_stall), 64'd1);
      check("starve_wb_prio", 64'(rf_rd),      64'd10);
      tick();
      wb_write = 1'b0;
      settle();
      check("drain1_rf_write", 64'(rf_write),  64'd1);
      check("drain1_rf_rd",    64'(rf_rd),     64'd1);
      check("drain1_wdata",    rf_wdata,       64'h101);
      check("drain1_stall",    64'(pipe_stall), 64'd1);
      check("drain1_ready",    64'(aux_ready), 64'd0);
      tick();
      settle();
      check("drain2_stall",   64'(pipe_stall),   64'd0);
      check("drain2_rf_rd",   64'(rf_rd),        64'd2);
      check("drain2_ready",   64'(aux_ready),    64'd1);
      check("drain2_pending", 64'(pending_mask), 64'h1C);
      tick();
      idle();
      settle();
      check("drain3_rf_rd",   64'(rf_rd),        64'd3);
      check("drain3_pending", 64'(pending_mask), 64'h38);
      tick();
      settle();
      check("drain4_rf_rd", 64'(rf_rd), 64'd4);
      tick();
      settle();
      check("drain5_rf_rd", 64'(rf_rd), 64'd5);
      check("drain5_wdata", rf_wdata,   64'h105);
      tick();
      settle();
      check("drained_rf_write", 64'(rf_write),     64'd0);
      check("drained_pending",  64'(pending_mask), 64'd0);

      // Fill with WB busy, then stream with WB idle and aux_valid held:
      // eight pushes in total exercise pointer wrap.
      set_wb(5'd30, 64'h3030);
      for (int k = 0; k < 4; k++) begin
         set_aux('{rd: 5'(16 + k), data: 64'(512 + 16 + k)});
         tick();
      end
      wb_write = 1'b0;
      set_aux('{rd: 5'd20, data: 64'h214});
      settle();
      check("wrap_full_ready", 64'(aux_ready),    64'd0);
      check("wrap_head_rd",    64'(rf_rd),        64'd16);
      check("wrap_pending",    64'(pending_mask), 64'h000F_0000);
      tick();
      for (int k = 1; k <= 7; k++) begin
         if (k <= 4) set_aux('{rd: 5'(19 + k), data: 64'(512 + 19 + k)});
         else        aux_valid = 1'b0;
         settle();
         check("wrap_rf_rd",  64'(rf_rd), 64'(16 + k));
         check("wrap_wdata",  rf_wdata,   64'(512 + 16 + k));
         if (k <= 4) check("wrap_ready", 64'(aux_ready), 64'd1);
         if (k == 1) check("wrap_pend_k1", 64'(pending_mask), 64'h000E_0000);
         if (k == 4) check("wrap_pend_k4", 64'(pending_mask), 64'h0070_0000);
         tick();
      end
      settle();
      check("wrap_end_rf_write", 64'(rf_write),     64'd0);
      check("wrap_end_pending",  64'(pending_mask), 64'd0);
      check("wrap_end_ready",    64'(aux_ready),    64'd1);

      // Register 0 on both sources: acknowledged, nothing written or buffered.
      set_wb(5'd0, 64'hFFFF);
      set_aux('{rd: 5'd0, data: 64'hBEEF});
      settle();
      check("r0_rf_write", 64'(rf_write),  64'd0);
      check("r0_rf_rd",    64'(rf_rd),     64'd0);
      check("r0_rf_wdata", rf_wdata,       64'd0);
      check("r0_ready",    64'(aux_ready), 64'd1);
      tick();
      idle();
      settle();
      check("r0_after_rf_write", 64'(rf_write),     64'd0);
      check("r0_after_pending",  64'(pending_mask), 64'd0);
      tick();

      // Reset with three entries buffered drops them silently.
      set_wb(5'd9, 64'h9999);
      for (int k = 0; k < 3; k++) begin
         set_aux('{rd: 5'(11 + k), data: 64'(768 + k)});
         tick();
      end
      aux_valid = 1'b0;
      settle();
      check("prerst_pending", 64'(pending_mask), 64'h3800);
      tick();
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      idle();
      settle();
      check("midrst_pending",  64'(pending_mask), 64'd0);
      check("midrst_rf_write", 64'(rf_write),     64'd0);
      check("midrst_ready",    64'(aux_ready),    64'd1);
      check("midrst_stall",    64'(pipe_stall),   64'd0);
      tick();
      settle();
      check("midrst_rf_write2", 64'(rf_write), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_reg_write_arbiter
